spi_flash_responder: RTL



---
 rtl/spi_flash_responder_if.sv | 26 ++
 rtl/spi_flash_responder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder_if.sv
// Bus bundle for spi_flash_responder: the SPI pins on the device side plus the byte-wide memory read port.
// The slave modport is the responder; the master modport is the SoC SPI master and the memory together.
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic              spi_sck_i;
  logic              spi_cs_i;
  logic              spi_mosi_i;
  logic              spi_miso_o;
  logic              spi_miso_oe_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic [7:0]        mem_data_i;
  logic              mem_ack_i;
  logic              underrun_o;

  modport slave (
    input  spi_sck_i, spi_cs_i, spi_mosi_i, mem_data_i, mem_ack_i,
    output spi_miso_o, spi_miso_oe_o, mem_addr_o, mem_rd_o, underrun_o
  );

  modport master (
    output spi_sck_i, spi_cs_i, spi_mosi_i, mem_data_i, mem_ack_i,
    input  spi_miso_o, spi_miso_oe_o, mem_addr_o, mem_rd_o, underrun_o
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator (READ 0x03, RDID 0x9F, RDSR 0x05) backed by a byte-wide memory port.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input logic                  clk32_i,
  input logic                  rst,
  spi_flash_responder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_ID, ST_STATUS, ST_IGNORE, ST_DATA, ST_DUMMY
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sck_sync_q, cs_sync_q, mosi_sync_q;
  logic        sck_prev_q, rise_q, fall_q;
  logic [2:0]  bit_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [6:0]  shift_q;
  logic [23:0] addr_q;
  logic [7:0]  tx_q, hold_q;
  logic        hold_valid_q, mem_rd_q, miso_q, underrun_q;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  logic        fast_q;
`endif

  logic       cs_high, mosi_bit, last_addr_bit;
  logic [7:0] mosi_byte;

  assign cs_high       = cs_sync_q[1];
  assign mosi_bit      = mosi_sync_q[1];
  assign mosi_byte     = {shift_q, mosi_bit};
  assign last_addr_bit = (state_q == ST_ADDR) && (byte_cnt_q == 2'd2) && (bit_cnt_q == 3'd7);

  // Edge pulses are registered, so SPI-side work happens 3 cycles after the pin edge.
  always_ff @(posedge clk32_i or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
      sck_sync_q  <= {sck_sync_q[0], bus.spi_sck_i};
      cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi_i};
      sck_prev_q  <= sck_sync_q[1];
      rise_q      <= sck_sync_q[1] & ~sck_prev_q;
      fall_q      <= ~sck_sync_q[1] & sck_prev_q;
    end
  end

  always_ff @(posedge clk32_i or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (cs_high) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD:
          if (rise_q && bit_cnt_q == 3'd7) begin
            case (mosi_byte)
              8'h03:   state_d = ST_ADDR;
              8'h9F:   state_d = ST_ID;
              8'h05:   state_d = ST_STATUS;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
              8'h0B:   state_d = ST_ADDR;
`endif
              default: state_d = ST_IGNORE;
            endcase
          end
        ST_ADDR:
          if (rise_q && last_addr_bit) begin
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            state_d = fast_q ? ST_DUMMY : ST_DATA;
`else
            state_d = ST_DATA;
`endif
          end
        ST_DUMMY: if (rise_q && bit_cnt_q == 3'd7) state_d = ST_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32_i or posedge rst) begin
    if (rst) begin
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 7'd0;
      addr_q       <= 24'd0;
      tx_q         <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      miso_q       <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
      fast_q       <= 1'b0;
`endif
    end else begin
      underrun_q <= 1'b0;
      if (cs_high) begin
        // Deselect abandons any request in flight; a late ack is simply not looked at.
        bit_cnt_q    <= 3'd0;
        byte_cnt_q   <= 2'd0;
        tx_q         <= 8'd0;
        hold_valid_q <= 1'b0;
        mem_rd_q     <= 1'b0;
        miso_q       <= 1'b0;
      end else begin
        if (mem_rd_q && bus.mem_ack_i) begin
          hold_q       <= bus.mem_data_i;
          hold_valid_q <= 1'b1;
          mem_rd_q     <= 1'b0;
        end
        if (rise_q) begin
          shift_q   <= mosi_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (state_q == ST_CMD && bit_cnt_q == 3'd7) begin
            byte_cnt_q <= 2'd0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            fast_q     <= (mosi_byte == 8'h0B);
`endif
          end
          if (state_q == ST_ADDR) begin
            addr_q <= {addr_q[22:0], mosi_bit};
            if (bit_cnt_q == 3'd7) byte_cnt_q <= byte_cnt_q + 2'd1;
            if (last_addr_bit) begin
              mem_rd_q   <= 1'b1;
              byte_cnt_q <= 2'd0;
            end
          end
        end
        if (fall_q) begin
          if (bit_cnt_q == 3'd0) begin
            case (state_q)
              ST_ID: begin
                case (byte_cnt_q)
                  2'd0:    {miso_q, tx_q} <= {JEDEC_ID[23:16], 1'b0};
                  2'd1:    {miso_q, tx_q} <= {JEDEC_ID[15:8], 1'b0};
                  default: {miso_q, tx_q} <= {JEDEC_ID[7:0], 1'b0};
                endcase
                byte_cnt_q <= (byte_cnt_q == 2'd2) ? 2'd0 : byte_cnt_q + 2'd1;
              end
              ST_DATA: begin
                if (hold_valid_q) begin
                  {miso_q, tx_q} <= {hold_q, 1'b0};
                end else begin
                  {miso_q, tx_q} <= {8'hFF, 1'b0};
                  underrun_q     <= 1'b1;
                end
                // Prefetch the next byte; the 24-bit address wraps naturally.
                hold_valid_q <= 1'b0;
                addr_q       <= addr_q + 24'd1;
                mem_rd_q     <= 1'b1;
              end
              default: {miso_q, tx_q} <= 9'd0;
            endcase
          end else begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign bus.spi_miso_o    = miso_q;
  assign bus.spi_miso_oe_o = ~cs_high;
  assign bus.mem_addr_o    = ADDR_W'(addr_q);
  assign bus.mem_rd_o      = mem_rd_q;
  assign bus.underrun_o    = underrun_q;

endmodule
